// File: rtl/mcycle_pkg.sv
// mcycle_pkg: shared opcodes, state encodings, ALU/mux codes and control bundle
package mcycle_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        RWB    = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11,
        TRAP   = 4'd12
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b10;
    localparam logic [1:0] ALUOP_FUNCT = 2'b01;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_4    = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       memToReg;
        logic       irWrite;
        logic       regDst;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSource;
        logic       illegalOp;
    } ctrl_t;

endpackage

// File: rtl/mcycle_control_if.sv
// mcycle_control_if: opcode/memory handshake in, datapath control strobes out
interface mcycle_control_if #(parameter int CNT_W = 32);
    logic [5:0]       opcode;
    logic             memReady;
    logic             pcWrite;
    logic             pcWriteCond;
    logic             iorD;
    logic             memRead;
    logic             memWrite;
    logic             memToReg;
    logic             irWrite;
    logic             regDst;
    logic             regWrite;
    logic             aluSrcA;
    logic [1:0]       aluSrcB;
    logic [1:0]       aluOp;
    logic [1:0]       pcSource;
    logic             illegalOp;
    logic [3:0]       state;
    logic [CNT_W-1:0] instrCount;

    modport master (
        input  opcode, memReady,
        output pcWrite, pcWriteCond, iorD, memRead, memWrite, memToReg, irWrite,
               regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource, illegalOp,
               state, instrCount
    );

    modport slave (
        output opcode, memReady,
        input  pcWrite, pcWriteCond, iorD, memRead, memWrite, memToReg, irWrite,
               regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource, illegalOp,
               state, instrCount
    );
endinterface

// File: rtl/mcycle_ctrl_decode.sv
// mcycle_ctrl_decode: combinational state + memReady -> datapath control strobes
module mcycle_ctrl_decode
    import mcycle_pkg::*;
(
    input  state_t state,
    input  logic   memReady,
    output ctrl_t  ctrl
);

    // every strobe defaults to 0; each state raises only what it needs
    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.memRead = 1'b1;
                ctrl.aluSrcB = SRCB_4;
                ctrl.irWrite = memReady;
                ctrl.pcWrite = memReady;
            end
            DECODE: ctrl.aluSrcB = SRCB_IMM2;
            MEMADR: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
            end
            MEMRD: begin
                ctrl.memRead = 1'b1;
                ctrl.iorD    = 1'b1;
            end
            MEMWB: begin
                ctrl.regWrite = 1'b1;
                ctrl.memToReg = 1'b1;
            end
            MEMWR: begin
                ctrl.memWrite = 1'b1;
                ctrl.iorD     = 1'b1;
            end
            EXEC: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluOp   = ALUOP_FUNCT;
            end
            RWB: begin
                ctrl.regWrite = 1'b1;
                ctrl.regDst   = 1'b1;
            end
            BRANCH: begin
                ctrl.aluSrcA     = 1'b1;
                ctrl.aluOp       = ALUOP_SUB;
                ctrl.pcWriteCond = 1'b1;
                ctrl.pcSource    = PCSRC_ALUOUT;
            end
            JUMP: begin
                ctrl.pcWrite  = 1'b1;
                ctrl.pcSource = PCSRC_JUMP;
            end
            ADDIEX: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
            end
            ADDIWB: ctrl.regWrite = 1'b1;
            TRAP: ctrl.illegalOp = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/mcycle_control.sv
// mcycle_control: multicycle MIPS main control FSM with retired-instruction counter
module mcycle_control
    import mcycle_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    mcycle_control_if.master  bus
);

    state_t           state_q;
    state_t           state_d;
    ctrl_t            ctrl;
    logic             retire;
    logic [CNT_W-1:0] count_q;

    mcycle_ctrl_decode u_decode (
        .state    (state_q),
        .memReady (bus.memReady),
        .ctrl     (ctrl)
    );

    // next state; unlisted states (writebacks, TRAP, unused codes) return to FETCH
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = bus.memReady ? DECODE : FETCH;
            DECODE: state_d = (bus.opcode == OP_LW || bus.opcode == OP_SW) ? MEMADR :
                              (bus.opcode == OP_R)    ? EXEC   :
                              (bus.opcode == OP_BEQ)  ? BRANCH :
                              (bus.opcode == OP_J)    ? JUMP   :
                              (bus.opcode == OP_ADDI) ? ADDIEX : TRAP;
            MEMADR: state_d = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  state_d = bus.memReady ? MEMWB : MEMRD;
            MEMWR:  state_d = bus.memReady ? FETCH : MEMWR;
            EXEC:   state_d = RWB;
            ADDIEX: state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    // an instruction retires when a completing state hands back to FETCH; TRAP does not count
    assign retire = (state_d == FETCH) &&
                    (state_q inside {MEMWB, MEMWR, RWB, BRANCH, JUMP, ADDIWB});

    // state register, asynchronously returned to FETCH
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= FETCH;
        else          state_q <= state_d;
    end

    // retired-instruction counter, wraps naturally
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)    count_q <= '0;
        else if (retire) count_q <= count_q + CNT_W'(1);
    end

    // PC/IR loads and memory requests are suppressed while reset is held so no
    // access is issued during an abort, even though FETCH itself requests a read
    assign bus.pcWrite     = reset_n & ctrl.pcWrite;
    assign bus.irWrite     = reset_n & ctrl.irWrite;
    assign bus.memRead     = reset_n & ctrl.memRead;
    assign bus.memWrite    = reset_n & ctrl.memWrite;
    assign bus.pcWriteCond = ctrl.pcWriteCond;
    assign bus.iorD        = ctrl.iorD;
    assign bus.memToReg    = ctrl.memToReg;
    assign bus.regDst      = ctrl.regDst;
    assign bus.regWrite    = ctrl.regWrite;
    assign bus.aluSrcA     = ctrl.aluSrcA;
    assign bus.aluSrcB     = ctrl.aluSrcB;
    assign bus.aluOp       = ctrl.aluOp;
    assign bus.pcSource    = ctrl.pcSource;
    assign bus.illegalOp   = ctrl.illegalOp;
    assign bus.state       = state_q;
    assign bus.instrCount  = count_q;

endmodule

// File: tb/tb_mcycle_control.sv
// tb_mcycle_control: directed instruction sequences against hand-computed control values
module tb_mcycle_control;

    logic clock;
    logic reset_n;
    int   tests;
    int   fails;

    mcycle_control_if #(.CNT_W(32)) bus ();

    mcycle_control #(.CNT_W(32)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset_n = 1'b0;
        bus.opcode = 6'b000000;
        bus.memReady = 1'b1;
        #3;
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_count", bus.instrCount, 0);
        chk("rst_memread", 32'(bus.memRead), 0);
        chk("rst_pcwrite", 32'(bus.pcWrite), 0);
        chk("rst_irwrite", 32'(bus.irWrite), 0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        // lw, memReady tied high: 0,1,2,3,4,0
        bus.opcode = 6'b100011;
        #1;
        chk("lw_s0", 32'(bus.state), 0);
        chk("lw_f_memread", 32'(bus.memRead), 1);
        chk("lw_f_irwrite", 32'(bus.irWrite), 1);
        chk("lw_f_srcb", 32'(bus.aluSrcB), 1);
        chk("lw_f_aluop", 32'(bus.aluOp), 0);
        chk("lw_f_regwrite", 32'(bus.regWrite), 0);
        cyc();
        chk("lw_s1", 32'(bus.state), 1);
        chk("lw_d_srcb", 32'(bus.aluSrcB), 3);
        chk("lw_d_aluop", 32'(bus.aluOp), 0);
        cyc();
        chk("lw_s2", 32'(bus.state), 2);
        chk("lw_a_srca", 32'(bus.aluSrcA), 1);
        chk("lw_a_srcb", 32'(bus.aluSrcB), 2);
        chk("lw_a_aluop", 32'(bus.aluOp), 0);
        cyc();
        chk("lw_s3", 32'(bus.state), 3);
        chk("lw_r_memread", 32'(bus.memRead), 1);
        chk("lw_r_iord", 32'(bus.iorD), 1);
        chk("lw_r_regwrite", 32'(bus.regWrite), 0);
        cyc();
        chk("lw_s4", 32'(bus.state), 4);
        chk("lw_wb_regwrite", 32'(bus.regWrite), 1);
        chk("lw_wb_memtoreg", 32'(bus.memToReg), 1);
        chk("lw_wb_regdst", 32'(bus.regDst), 0);
        chk("lw_wb_count", bus.instrCount, 0);
        cyc();
        chk("lw_s5", 32'(bus.state), 0);
        chk("lw_count", bus.instrCount, 1);
        // R-type with memReady low for two FETCH cycles
        bus.opcode = 6'b000000;
        bus.memReady = 1'b0;
        #1;
        chk("r_f0_state", 32'(bus.state), 0);
        chk("r_f0_irwrite", 32'(bus.irWrite), 0);
        chk("r_f0_pcwrite", 32'(bus.pcWrite), 0);
        cyc();
        chk("r_f1_state", 32'(bus.state), 0);
        chk("r_f1_irwrite", 32'(bus.irWrite), 0);
        bus.memReady = 1'b1;
        #1;
        chk("r_f2_irwrite", 32'(bus.irWrite), 1);
        chk("r_f2_pcwrite", 32'(bus.pcWrite), 1);
        cyc();
        chk("r_s1", 32'(bus.state), 1);
        chk("r_d_pcwrite", 32'(bus.pcWrite), 0);
        cyc();
        chk("r_s6", 32'(bus.state), 6);
        chk("r_ex_aluop", 32'(bus.aluOp), 1);
        chk("r_ex_srca", 32'(bus.aluSrcA), 1);
        chk("r_ex_srcb", 32'(bus.aluSrcB), 0);
        cyc();
        chk("r_s7", 32'(bus.state), 7);
        chk("r_wb_regdst", 32'(bus.regDst), 1);
        chk("r_wb_regwrite", 32'(bus.regWrite), 1);
        chk("r_wb_memtoreg", 32'(bus.memToReg), 0);
        cyc();
        chk("r_s0", 32'(bus.state), 0);
        chk("r_count", bus.instrCount, 2);
        // beq
        bus.opcode = 6'b000100;
        cyc();
        chk("beq_s1", 32'(bus.state), 1);
        cyc();
        chk("beq_s8", 32'(bus.state), 8);
        chk("beq_aluop", 32'(bus.aluOp), 2);
        chk("beq_pcwcond", 32'(bus.pcWriteCond), 1);
        chk("beq_pcsrc", 32'(bus.pcSource), 1);
        chk("beq_pcwrite", 32'(bus.pcWrite), 0);
        cyc();
        chk("beq_s0", 32'(bus.state), 0);
        chk("beq_count", bus.instrCount, 3);
        // unsupported opcode traps without retiring
        bus.opcode = 6'b111111;
        cyc();
        chk("ill_s1", 32'(bus.state), 1);
        chk("ill_d_flag", 32'(bus.illegalOp), 0);
        cyc();
        chk("ill_s12", 32'(bus.state), 12);
        chk("ill_flag", 32'(bus.illegalOp), 1);
        chk("ill_regwrite", 32'(bus.regWrite), 0);
        chk("ill_memwrite", 32'(bus.memWrite), 0);
        cyc();
        chk("ill_s0", 32'(bus.state), 0);
        chk("ill_flag_off", 32'(bus.illegalOp), 0);
        chk("ill_count", bus.instrCount, 3);
        // sw with memReady low for three MEMWR cycles
        bus.opcode = 6'b101011;
        cyc();
        cyc();
        chk("sw_s2", 32'(bus.state), 2);
        bus.memReady = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("sw_wait%0d_state", i), 32'(bus.state), 5);
            chk($sformatf("sw_wait%0d_memwrite", i), 32'(bus.memWrite), 1);
            chk($sformatf("sw_wait%0d_iord", i), 32'(bus.iorD), 1);
            cyc();
        end
        bus.memReady = 1'b1;
        #1;
        chk("sw_last_state", 32'(bus.state), 5);
        chk("sw_last_memwrite", 32'(bus.memWrite), 1);
        chk("sw_last_count", bus.instrCount, 3);
        cyc();
        chk("sw_s0", 32'(bus.state), 0);
        chk("sw_memwrite_off", 32'(bus.memWrite), 0);
        chk("sw_count", bus.instrCount, 4);
        // j
        bus.opcode = 6'b000010;
        cyc();
        cyc();
        chk("j_s9", 32'(bus.state), 9);
        chk("j_pcwrite", 32'(bus.pcWrite), 1);
        chk("j_pcsrc", 32'(bus.pcSource), 2);
        cyc();
        chk("j_count", bus.instrCount, 5);
        // addi
        bus.opcode = 6'b001000;
        cyc();
        cyc();
        chk("addi_s10", 32'(bus.state), 10);
        chk("addi_srcb", 32'(bus.aluSrcB), 2);
        chk("addi_srca", 32'(bus.aluSrcA), 1);
        cyc();
        chk("addi_s11", 32'(bus.state), 11);
        chk("addi_regwrite", 32'(bus.regWrite), 1);
        chk("addi_regdst", 32'(bus.regDst), 0);
        chk("addi_memtoreg", 32'(bus.memToReg), 0);
        cyc();
        chk("addi_count", bus.instrCount, 6);
        // reset pulsed in MEMRD
        bus.opcode = 6'b100011;
        cyc();
        cyc();
        bus.memReady = 1'b0;
        cyc();
        chk("ar_s3", 32'(bus.state), 3);
        chk("ar_memread_pre", 32'(bus.memRead), 1);
        reset_n = 1'b0;
        #1;
        chk("ar_state", 32'(bus.state), 0);
        chk("ar_count", bus.instrCount, 0);
        chk("ar_memread", 32'(bus.memRead), 0);
        chk("ar_memwrite", 32'(bus.memWrite), 0);
        cyc();
        chk("ar_hold_state", 32'(bus.state), 0);
        chk("ar_hold_memread", 32'(bus.memRead), 0);
        reset_n = 1'b1;
        bus.memReady = 1'b1;
        bus.opcode = 6'b000010;
        #1;
        chk("ar_rel_memread", 32'(bus.memRead), 1);
        chk("ar_rel_irwrite", 32'(bus.irWrite), 1);
        cyc();
        chk("ar_rel_s1", 32'(bus.state), 1);
        cyc();
        chk("ar_rel_s9", 32'(bus.state), 9);
        cyc();
        chk("ar_rel_s0", 32'(bus.state), 0);
        chk("ar_rel_count", bus.instrCount, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
